// File: rtl/reg_arb_pkg.sv
// reg_arb_pkg: shared state encoding and limits for the register load arbiter
package reg_arb_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, WAIT, CLR} state_t;
    localparam int MAX_NREQ = 8;
endpackage

// File: rtl/reg_load_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set request at or after ptr
module rr_pick #(
    parameter  int NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic            valid_o,
    output logic [IW-1:0]   idx_o
);
    localparam logic [IW:0] NR = (IW+1)'(NREQ);
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [IW:0]       sum;
    logic [IW:0]       wrap;
    always_comb begin
        dbl = {req_i, req_i} >> ptr_i;
        rot = dbl[NREQ-1:0];
        valid_o = |req_i;
        sum = '0;
        for (int j = NREQ - 1; j >= 0; j--)
            if (rot[j]) sum = j[IW:0];
        sum = sum + {1'b0, ptr_i};
        wrap = (sum >= NR) ? sum - NR : sum;
        idx_o = wrap[IW-1:0];
    end
endmodule

// File: rtl/reg_load_arbiter.sv
// reg_load_arbiter: round-robin req/gnt sequencer driving one shared load/clear register
module reg_load_arbiter
    import reg_arb_pkg::*;
#(
    parameter  int N    = 8,
    parameter  int NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic [NREQ-1:0]   req_i,
    input  logic [NREQ*N-1:0] wdata_i,
    input  logic              clr_req_i,
    output logic [NREQ-1:0]   gnt_o,
    output logic [N-1:0]      reg_in_o,
    output logic              reg_load_o,
    output logic              reg_clear_o,
    output logic [IW-1:0]     owner_o,
    output logic              busy_o
);
    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [N-1:0]      reg_in_q, reg_in_d;
    logic              load_q, load_d;
    logic              clear_q, clear_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic              busy_q;
    logic              pick_valid;
    logic [IW-1:0]     pick_idx;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        reg_in_d = reg_in_q;
        load_d   = load_q;
        clear_d  = clear_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        case (state_q)
            IDLE: begin
                if (clr_req_i) begin
                    state_d = CLR;
                    clear_d = 1'b1;
                end else if (pick_valid) begin
                    state_d  = LOAD;
                    gnt_d    = NREQ'(1) << pick_idx;
                    reg_in_d = wdata_i[pick_idx*N +: N];
                    load_d   = 1'b1;
                    owner_d  = pick_idx;
                end
            end
            LOAD: begin
                state_d = WAIT;
                load_d  = 1'b0;
            end
            WAIT: begin
                // release only once the owner has seen its grant and dropped req
                if (!req_i[owner_q]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                clear_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            reg_in_q <= '0;
            load_q   <= 1'b0;
            clear_q  <= 1'b0;
            owner_q  <= '0;
            ptr_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            reg_in_q <= reg_in_d;
            load_q   <= load_d;
            clear_q  <= clear_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            busy_q   <= (state_d != IDLE);
        end
    end

    assign gnt_o       = gnt_q;
    assign reg_in_o    = reg_in_q;
    assign reg_load_o  = load_q;
    assign reg_clear_o = clear_q;
    assign owner_o     = owner_q;
    assign busy_o      = busy_q;
endmodule

// File: tb/tb_reg_load_arbiter.sv
// tb_reg_load_arbiter: table-driven check of arbitration, clear priority and async abort
module tb_reg_load_arbiter;
    localparam int N = 8;
    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              clear_n = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*N-1:0] wdata = 32'h44A5_2211;
    logic              clr_req = 1'b0;
    logic [NREQ-1:0]   gnt;
    logic [N-1:0]      reg_in;
    logic              reg_load;
    logic              reg_clear;
    logic [1:0]        owner;
    logic              busy;
    logic [N-1:0]      reg_m = 8'hFF;
    int                n_cmp = 0;
    int                n_bad = 0;

    typedef struct {
        logic [3:0] req;
        logic       clr;
        logic [3:0] gnt;
        logic [7:0] rin;
        logic       ld;
        logic       cl;
        logic [1:0] own;
        logic       bsy;
        logic [7:0] rv;
    } vec_t;

    vec_t tv[33];

    reg_load_arbiter #(.N(N), .NREQ(NREQ)) dut (
        .clk         (clk),
        .clear_n     (clear_n),
        .req_i       (req),
        .wdata_i     (wdata),
        .clr_req_i   (clr_req),
        .gnt_o       (gnt),
        .reg_in_o    (reg_in),
        .reg_load_o  (reg_load),
        .reg_clear_o (reg_clear),
        .owner_o     (owner),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    // the shared register the arbiter drives
    always @(posedge clk) begin
        if (reg_clear) reg_m <= 8'h00;
        else if (reg_load) reg_m <= reg_in;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("excl_load_clear", {31'b0, reg_load & reg_clear}, 32'h0);
        chk("gnt_onehot0", {31'b0, $onehot0(gnt)}, 32'h1);
    end

    initial begin
        tv[0]  = '{4'b1111, 1'b0, 4'b0001, 8'h11, 1'b1, 1'b0, 2'd0, 1'b1, 8'hFF};
        tv[1]  = '{4'b1110, 1'b0, 4'b0001, 8'h11, 1'b0, 1'b0, 2'd0, 1'b1, 8'h11};
        tv[2]  = '{4'b1110, 1'b0, 4'b0000, 8'h11, 1'b0, 1'b0, 2'd0, 1'b0, 8'h11};
        tv[3]  = '{4'b1110, 1'b0, 4'b0010, 8'h22, 1'b1, 1'b0, 2'd1, 1'b1, 8'h11};
        tv[4]  = '{4'b1100, 1'b0, 4'b0010, 8'h22, 1'b0, 1'b0, 2'd1, 1'b1, 8'h22};
        tv[5]  = '{4'b1100, 1'b0, 4'b0000, 8'h22, 1'b0, 1'b0, 2'd1, 1'b0, 8'h22};
        tv[6]  = '{4'b1100, 1'b0, 4'b0100, 8'hA5, 1'b1, 1'b0, 2'd2, 1'b1, 8'h22};
        tv[7]  = '{4'b1000, 1'b0, 4'b0100, 8'hA5, 1'b0, 1'b0, 2'd2, 1'b1, 8'hA5};
        tv[8]  = '{4'b1000, 1'b0, 4'b0000, 8'hA5, 1'b0, 1'b0, 2'd2, 1'b0, 8'hA5};
        tv[9]  = '{4'b1000, 1'b0, 4'b1000, 8'h44, 1'b1, 1'b0, 2'd3, 1'b1, 8'hA5};
        tv[10] = '{4'b0001, 1'b0, 4'b1000, 8'h44, 1'b0, 1'b0, 2'd3, 1'b1, 8'h44};
        tv[11] = '{4'b0001, 1'b0, 4'b0000, 8'h44, 1'b0, 1'b0, 2'd3, 1'b0, 8'h44};
        tv[12] = '{4'b0001, 1'b0, 4'b0001, 8'h11, 1'b1, 1'b0, 2'd0, 1'b1, 8'h44};
        tv[13] = '{4'b0000, 1'b0, 4'b0001, 8'h11, 1'b0, 1'b0, 2'd0, 1'b1, 8'h11};
        tv[14] = '{4'b0000, 1'b0, 4'b0000, 8'h11, 1'b0, 1'b0, 2'd0, 1'b0, 8'h11};
        tv[15] = '{4'b0010, 1'b1, 4'b0000, 8'h11, 1'b0, 1'b1, 2'd0, 1'b1, 8'h11};
        tv[16] = '{4'b0010, 1'b0, 4'b0000, 8'h11, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00};
        tv[17] = '{4'b0010, 1'b0, 4'b0010, 8'h22, 1'b1, 1'b0, 2'd1, 1'b1, 8'h00};
        tv[18] = '{4'b0000, 1'b0, 4'b0010, 8'h22, 1'b0, 1'b0, 2'd1, 1'b1, 8'h22};
        tv[19] = '{4'b0000, 1'b0, 4'b0000, 8'h22, 1'b0, 1'b0, 2'd1, 1'b0, 8'h22};
        tv[20] = '{4'b0100, 1'b0, 4'b0100, 8'hA5, 1'b1, 1'b0, 2'd2, 1'b1, 8'h22};
        tv[21] = '{4'b0100, 1'b0, 4'b0100, 8'hA5, 1'b0, 1'b0, 2'd2, 1'b1, 8'hA5};
        tv[22] = '{4'b0100, 1'b1, 4'b0100, 8'hA5, 1'b0, 1'b0, 2'd2, 1'b1, 8'hA5};
        tv[23] = '{4'b0100, 1'b0, 4'b0100, 8'hA5, 1'b0, 1'b0, 2'd2, 1'b1, 8'hA5};
        tv[24] = '{4'b0000, 1'b0, 4'b0000, 8'hA5, 1'b0, 1'b0, 2'd2, 1'b0, 8'hA5};
        tv[25] = '{4'b1001, 1'b0, 4'b1000, 8'h44, 1'b1, 1'b0, 2'd3, 1'b1, 8'hA5};
        tv[26] = '{4'b0001, 1'b0, 4'b1000, 8'h44, 1'b0, 1'b0, 2'd3, 1'b1, 8'h44};
        tv[27] = '{4'b0001, 1'b0, 4'b0000, 8'h44, 1'b0, 1'b0, 2'd3, 1'b0, 8'h44};
        tv[28] = '{4'b0001, 1'b0, 4'b0001, 8'h11, 1'b1, 1'b0, 2'd0, 1'b1, 8'h44};
        tv[29] = '{4'b0001, 1'b0, 4'b0001, 8'h11, 1'b0, 1'b0, 2'd0, 1'b1, 8'h11};
        tv[30] = '{4'b0000, 1'b0, 4'b0000, 8'h11, 1'b0, 1'b0, 2'd0, 1'b0, 8'h11};
        tv[31] = '{4'b0100, 1'b0, 4'b0100, 8'hA5, 1'b1, 1'b0, 2'd2, 1'b1, 8'h11};
        tv[32] = '{4'b0100, 1'b0, 4'b0100, 8'hA5, 1'b0, 1'b0, 2'd2, 1'b1, 8'hA5};

        req = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", {28'b0, gnt}, 32'h0);
        chk("rst_load_clear", {30'b0, reg_load, reg_clear}, 32'h0);
        chk("rst_busy_owner", {29'b0, busy, owner}, 32'h0);
        chk("rst_reg_in", {24'b0, reg_in}, 32'h0);
        clear_n = 1'b1;

        for (int i = 0; i < 33; i++) begin
            req = tv[i].req;
            clr_req = tv[i].clr;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i),
                {7'b0, gnt, reg_in, reg_load, reg_clear, owner, busy, reg_m},
                {7'b0, tv[i].gnt, tv[i].rin, tv[i].ld, tv[i].cl, tv[i].own, tv[i].bsy, tv[i].rv});
        end

        #3 clear_n = 1'b0;
        #1;
        chk("abort_gnt", {28'b0, gnt}, 32'h0);
        chk("abort_busy_owner", {29'b0, busy, owner}, 32'h0);
        chk("abort_reg_in_load", {23'b0, reg_in, reg_load}, 32'h0);
        req = 4'b1111;
        #2 clear_n = 1'b1;
        @(posedge clk);
        #1;
        chk("restart_grant", {21'b0, gnt, reg_in, owner, busy}, {21'b0, 4'b0001, 8'h11, 2'd0, 1'b1});
        req = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        chk("restart_idle", {27'b0, gnt, busy}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/reg_load_arbiter.md
Name: reg_load_arbiter

Overview:
- Round-robin arbiter and sequencer that lets NREQ requesters share one N-bit load/clear register.
- Sits between the requesters and the register instance; drives the register's in, load and clear pins.
- Requesters use a 4-phase req/gnt handshake. A separate clear request zeroes the register.
- Exactly one agent modifies the register at a time, and every write is acknowledged.

Parameters:
- N, 8, data width of the shared register and of each requester's write data.
- NREQ, 4, number of requesters; legal range 2..8. IW = $clog2(NREQ).

Ports:
- clk  input  1  rising-edge clock.
- clear_n  input  1  asynchronous, active-low reset.
- req  input  NREQ  per-requester write request; level-held until gnt seen, then dropped.
- wdata  input  NREQ*N  packed write data; slice i = wdata[i*N +: N]; must be stable while req[i]=1.
- clr_req  input  1  single-cycle request to zero the shared register.
- gnt  output  NREQ  one-hot grant; all zero when no owner.
- reg_in  output  N  data to the register's in pin.
- reg_load  output  1  load strobe to the register.
- reg_clear  output  1  synchronous clear strobe to the register, one cycle.
- owner  output  IW  index of the current or most recent grantee.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- All outputs are registered.
- While clear_n=0: state=IDLE, gnt=0, reg_in=0, reg_load=0, reg_clear=0, owner=0, busy=0, round-robin pointer ptr=0.
- FSM states: IDLE, LOAD, WAIT, CLR.
- IDLE, clr_req=1:
  - Next state is CLR with reg_clear<=1.
  - clr_req has priority over req in the same cycle.
- IDLE, any req bit=1 and clr_req=0:
  - Select i = first set req bit searching ptr, ptr+1, ... with wrap at NREQ-1 -> 0.
  - Set gnt<=onehot(i), reg_in<=wdata slice i, reg_load<=1, owner<=i, busy<=1. Next state is LOAD.
- LOAD (exactly one cycle):
  - The register captures reg_in at the closing edge.
  - Set reg_load<=0; gnt is held. Next state is WAIT.
- WAIT:
  - Hold gnt until req[owner]=0.
  - Then set gnt<=0, ptr<=(owner+1) mod NREQ, busy<=0. Next state is IDLE.
- CLR (one cycle):
  - Set reg_clear<=0. Next state is IDLE. ptr is unchanged.
- clr_req arriving outside IDLE is dropped, not queued. Requesters that need guaranteed clears must wait for busy=0.
- Latency:
  - req sampled at edge k -> gnt and reg_load visible after edge k -> register updated at edge k+1.
  - The minimum transaction is 3 cycles, IDLE->LOAD->WAIT->IDLE, when req drops immediately after gnt.
- reg_load and reg_clear are never high in the same cycle, and at most one gnt bit is high.
- Requests from other requesters during LOAD or WAIT are ignored until IDLE. No starvation: each requester is served within NREQ grants.
- If req[owner] drops during LOAD, the load still completes, and WAIT exits on its first cycle.
- clear_n asserted mid-transaction aborts immediately to reset values. A partial load is impossible because the register captures only while reg_load=1.
- A gnt bit rises only from IDLE, so re-arbitration needs at least one IDLE cycle.

Decomposition:
- Package reg_arb_pkg holds:
  - enum state_t {IDLE, LOAD, WAIT, CLR} (2-bit).
  - Localparam MAX_NREQ=8.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req[NREQ], ptr[IW].
  - Outputs: valid, idx[IW].
  - Implemented by double-width rotate-and-priority-encode.
- The top-level FSM instantiates rr_pick once.

Test Plan:
- Reset: hold clear_n=0 with req=4'b1111 -> gnt=0, reg_load=0, busy=0, owner=0. Release -> next edge grants requester 0.
- Single write: req[2]=1, wdata slice 2=8'hA5 -> next cycle gnt=4'b0100, reg_in=8'hA5, reg_load=1. Register reads 8'hA5 one cycle later. Drop req[2] -> gnt=0, busy=0, ptr=3.
- Fairness: req=4'b1111 held, each requester drops req one cycle after its grant -> grant order 0,1,2,3,0. No requester is granted twice within 4 grants.
- Clear priority: in IDLE, clr_req=1 and req[1]=1 in the same cycle -> reg_clear=1 for one cycle, register=8'h00. gnt[1] follows after returning to IDLE.
- Dropped clear: clr_req pulse during WAIT -> no reg_clear pulse; register keeps 8'hA5.
- Async abort: assert clear_n low mid-WAIT, not on a clock edge -> gnt and busy go to 0 immediately. After release, arbitration restarts from ptr=0.
